// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_e : FSM encoding (the S_VEC_* states are only reachable when
//                   RESET_VECTOR_FETCH_EN is defined)
//   IMM_BIT       : instruction-word bit that marks a 2-word instruction
//   VEC_LO_ADDR / VEC_HI_ADDR : memory words that hold the reset vector
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_IMM    = 2'd1,
        S_VEC_LO = 2'd2,
        S_VEC_HI = 2'd3
    } fetch_state_e;

    localparam int unsigned IMM_BIT     = 0;
    localparam int unsigned VEC_LO_ADDR = 0;
    localparam int unsigned VEC_HI_ADDR = 1;

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC select for the fetch stage.
// Ports:
//   redirect, redirect_addr : taken branch/jump and its target (highest priority)
//   vec_load, vec_addr      : load the PC from the reset-vector path
//   stall                   : hold the PC
//   advance                 : step to PC+1 (wraps modulo 2^ADDR_W)
//   pc                      : current PC register
//   pc_inc                  : PC+1, shared with the IF/ID pc_next field
//   pc_next                 : value for the PC register on the next edge
module fetch_pc_sel #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              redirect,
    input  logic              stall,
    input  logic              advance,
    input  logic              vec_load,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic [ADDR_W-1:0] vec_addr,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [ADDR_W-1:0] pc_next
);

    always_comb begin
        pc_inc  = pc + ADDR_W'(1);
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_addr;
        end else if (vec_load) begin
            pc_next = vec_addr;
        end else if (stall) begin
            pc_next = pc;
        end else if (advance) begin
            pc_next = pc_inc;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the PC, drives the instruction memory and loads
// the IF/ID buffer with 1-word instructions or 2-word (instr + immediate)
// instructions, marked by bit IMM_BIT of the first word.
// Optional feature: define RESET_VECTOR_FETCH_EN to load the PC from memory
// words 0 (low) and 1 (high) after reset instead of using RESET_PC.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : word address (equals the PC register)
//   imem_rd         : read strobe, low only while rst is asserted
//   imem_rdata      : asynchronous read data for imem_addr
//   stall           : freeze PC, FSM and IF/ID
//   redirect        : taken branch/jump; redirect_addr is the target
//   if_id_valid     : IF/ID holds a complete instruction
//   if_id_instr     : instruction word
//   if_id_imm       : immediate word (0 for 1-word instructions)
//   if_id_pc_next   : address after the last consumed word
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_imm,
    output logic [ADDR_W-1:0]  if_id_pc_next
);

`ifdef RESET_VECTOR_FETCH_EN
    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(VEC_LO_ADDR);
    localparam fetch_state_e      STATE_RST = S_VEC_LO;
`else
    localparam logic [ADDR_W-1:0] PC_RST    = RESET_PC;
    localparam fetch_state_e      STATE_RST = S_FETCH;
`endif

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0]  pcn_q, pcn_d;

    logic              sel_redirect;
    logic              sel_stall;
    logic              advance;
    logic              vec_load;
    logic [ADDR_W-1:0] vec_addr;

    fetch_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_sel (
        .redirect      (sel_redirect),
        .stall         (sel_stall),
        .advance       (advance),
        .vec_load      (vec_load),
        .redirect_addr (redirect_addr),
        .vec_addr      (vec_addr),
        .pc            (pc_q),
        .pc_inc        (pc_inc),
        .pc_next       (pc_d)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        imm_d        = imm_q;
        pcn_d        = pcn_q;
        sel_redirect = 1'b0;
        sel_stall    = 1'b0;
        advance      = 1'b0;
        vec_load     = 1'b0;
        vec_addr     = '0;

        case (state_q)
            S_FETCH, S_IMM: begin
                sel_redirect = redirect;
                sel_stall    = stall;
                if (redirect) begin
                    // Any half-assembled 2-word instruction is simply dropped.
                    state_d = S_FETCH;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    advance = 1'b1;
                    if (state_q == S_IMM) begin
                        instr_d = hold_q;
                        imm_d   = imem_rdata;
                        valid_d = 1'b1;
                        pcn_d   = pc_inc;
                        state_d = S_FETCH;
                    end else if (imem_rdata[IMM_BIT]) begin
                        hold_d  = imem_rdata;
                        valid_d = 1'b0;
                        state_d = S_IMM;
                    end else begin
                        instr_d = imem_rdata;
                        imm_d   = '0;
                        valid_d = 1'b1;
                        pcn_d   = pc_inc;
                    end
                end
            end
`ifdef RESET_VECTOR_FETCH_EN
            S_VEC_LO: begin
                hold_d   = imem_rdata;
                vec_load = 1'b1;
                vec_addr = ADDR_W'(VEC_HI_ADDR);
                valid_d  = 1'b0;
                state_d  = S_VEC_HI;
            end
            S_VEC_HI: begin
                vec_load = 1'b1;
                vec_addr = ADDR_W'({imem_rdata, hold_q});
                valid_d  = 1'b0;
                state_d  = S_FETCH;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_RST;
            pc_q    <= PC_RST;
            hold_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
            pcn_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            pcn_q   <= pcn_d;
        end
    end

    assign imem_addr     = pc_q;
    assign imem_rd       = ~rst;
    assign if_id_valid   = valid_q;
    assign if_id_instr   = instr_q;
    assign if_id_imm     = imm_q;
    assign if_id_pc_next = pcn_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller (default build, vector fetch off).
// A behavioural model tracks the PC and a "half instruction pending" flag
// and predicts the IF/ID contents each cycle.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_rdata;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_imm;
    logic [31:0] if_id_pc_next;

    logic [15:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc;
    logic        m_partial;
    logic [15:0] m_first;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_imm;
    logic [31:0] m_pcn;

    wire [96:0] dut_vec = {if_id_valid, if_id_instr, if_id_imm, if_id_pc_next, imem_addr};
    wire [96:0] exp_vec = {m_valid, m_instr, m_imm, m_pcn, m_pc};

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[9:0]];

    fetch_controller dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_imm     (if_id_imm),
        .if_id_pc_next (if_id_pc_next)
    );

    // One clock edge; the model consumes the word at its own PC.
    task automatic tick();
        logic [15:0] w;
        w = mem[m_pc[9:0]];
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_partial = 1'b0; m_first = '0;
            m_valid = 1'b0; m_instr = '0; m_imm = '0; m_pcn = '0;
        end else if (redirect) begin
            m_pc = redirect_addr; m_partial = 1'b0; m_valid = 1'b0;
        end else if (!stall) begin
            m_pc = m_pc + 32'd1;
            if (m_partial) begin
                m_valid = 1'b1; m_instr = m_first; m_imm = w; m_pcn = m_pc; m_partial = 1'b0;
            end else if (w[0]) begin
                m_first = w; m_partial = 1'b1; m_valid = 1'b0;
            end else begin
                m_valid = 1'b1; m_instr = w; m_imm = '0; m_pcn = m_pc;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
        tick(); tick();
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec);
        end
        checks++;
        if (dut_vec !== 97'd0) begin
            errors++;
            $display("FAIL reset_zero: got %h want 0", dut_vec);
        end
        checks++;
        if (imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: got %b want 0", imem_rd);
        end
    endtask

    task automatic test_single_word();
        logic [15:0] exp_i [3];
        exp_i[0] = 16'h1230; exp_i[1] = 16'h4560; exp_i[2] = 16'h7890;
        mem[0] = 16'h1230; mem[1] = 16'h4560; mem[2] = 16'h7890; mem[3] = 16'h0002;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL single_model[%0d]: got %h want %h", i, dut_vec, exp_vec);
            end
            checks++;
            if ({if_id_valid, if_id_instr, if_id_pc_next} !== {1'b1, exp_i[i], 32'(i + 1)}) begin
                errors++;
                $display("FAIL single_const[%0d]: got v=%b i=%h pn=%h want v=1 i=%h pn=%0d",
                         i, if_id_valid, if_id_instr, if_id_pc_next, exp_i[i], i + 1);
            end
        end
        checks++;
        if (imem_rd !== 1'b1) begin
            errors++;
            $display("FAIL single_rd: got %b want 1", imem_rd);
        end
    endtask

    task automatic test_two_word();
        mem[4] = 16'hA001; mem[5] = 16'hBEEF;
        redirect = 1'b1; redirect_addr = 32'd4; tick(); redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL two_word_model[%0d]: got %h want %h", i, dut_vec, exp_vec);
            end
        end
        checks++;
        if ({if_id_valid, if_id_instr, if_id_imm, if_id_pc_next} !==
            {1'b1, 16'hA001, 16'hBEEF, 32'd6}) begin
            errors++;
            $display("FAIL two_word_const: got v=%b i=%h imm=%h pn=%h want 1 A001 BEEF 6",
                     if_id_valid, if_id_instr, if_id_imm, if_id_pc_next);
        end
    endtask

    task automatic test_stall();
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec || imem_addr !== 32'd1 || if_id_instr !== 16'h1230) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_vec, exp_vec);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (dut_vec !== exp_vec || if_id_instr !== 16'h4560) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_redirect_imm();
        mem[32'h40] = 16'h5550;
        redirect = 1'b1; redirect_addr = 32'd4; tick(); redirect = 1'b0;
        tick();
        redirect = 1'b1; redirect_addr = 32'h40; tick(); redirect = 1'b0;
        checks++;
        if (dut_vec !== exp_vec || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_bubble: got %h want %h", dut_vec, exp_vec);
        end
        tick();
        checks++;
        if ({if_id_valid, if_id_instr, if_id_imm, if_id_pc_next} !==
            {1'b1, 16'h5550, 16'h0000, 32'h41}) begin
            errors++;
            $display("FAIL redirect_target: got v=%b i=%h imm=%h pn=%h want 1 5550 0000 41",
                     if_id_valid, if_id_instr, if_id_imm, if_id_pc_next);
        end
    endtask

    task automatic test_stall_redirect_reset();
        mem[32'h80] = 16'h3331;
        stall = 1'b1; redirect = 1'b1; redirect_addr = 32'h80; tick();
        stall = 1'b0; redirect = 1'b0;
        checks++;
        if (imem_addr !== 32'h80 || if_id_valid !== 1'b0 || dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL stall_redirect: got addr=%h v=%b want addr=80 v=0",
                     imem_addr, if_id_valid);
        end
        tick();
        rst = 1'b1; tick();
        checks++;
        if (dut_vec !== 97'd0 || imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_imm: got %h rd=%b want 0 rd=0", dut_vec, imem_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        mem[1023] = 16'h2222;
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF; tick(); redirect = 1'b0;
        tick();
        checks++;
        if (if_id_pc_next !== 32'd0 || imem_addr !== 32'd0 || if_id_instr !== 16'h2222) begin
            errors++;
            $display("FAIL wrap: got pn=%h addr=%h i=%h want 0 0 2222",
                     if_id_pc_next, imem_addr, if_id_instr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 7) == 0);
            redirect_addr = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                                        : 32'($urandom_range(0, 1023));
            tick();
            checks++;
            if (dut_vec !== exp_vec || imem_rd !== !rst) begin
                errors++;
                $display("FAIL random[%0d]: got %h rd=%b want %h rd=%b",
                         i, dut_vec, imem_rd, exp_vec, !rst);
            end
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        m_pc = '0; m_partial = 1'b0; m_first = '0;
        m_valid = 1'b0; m_instr = '0; m_imm = '0; m_pcn = '0;
        test_reset();
        test_single_word();
        test_two_word();
        test_stall();
        test_redirect_imm();
        test_stall_redirect_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
